uart_phy: RTL

//  Byte-level UART serializer/deserializer (8N1; optional parity) feeding the uart2wb command parser.

---
 rtl/uart_phy_pkg.sv | 40 ++++
 rtl/uart_tx_ser.sv | 69 ++++++
 rtl/uart_phy.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/uart_phy_pkg.sv
// Shared constants for the uart_phy byte-level serial PHY: frame geometry and FSM encodings.
// Latency: n/a (definitions only).
// Backpressure: n/a. Even parity is enabled by defining UART_PARITY_EN.
package uart_phy_pkg;

    localparam int   DATA_BITS  = 8;
    localparam int   BAUD_CNT_W = 16;
    localparam int   BIT_CNT_W  = 4;
    localparam logic LINE_IDLE  = 1'b1;

`ifdef UART_PARITY_EN
    // start + data + parity + stop
    localparam int FRAME_BITS = DATA_BITS + 3;
`else
    // start + data + stop
    localparam int FRAME_BITS = DATA_BITS + 2;
`endif

    // Receiver states
    localparam logic [2:0] RX_IDLE   = 3'd0;
    localparam logic [2:0] RX_START  = 3'd1;
    localparam logic [2:0] RX_DATA   = 3'd2;
    localparam logic [2:0] RX_STOP   = 3'd4;
    localparam logic [2:0] RX_BREAK  = 3'd5;
`ifdef UART_PARITY_EN
    localparam logic [2:0] RX_PARITY = 3'd3;
`endif

    // Transmitter states
    localparam logic [0:0] TX_IDLE = 1'b0;
    localparam logic [0:0] TX_SEND = 1'b1;

`ifdef UART_PARITY_EN
    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction
`endif

endpackage

// File: rtl/uart_tx_ser.sv
// UART transmit serializer: start, 8 data bits LSB first, optional even parity, one stop bit.
// Latency: line drives the start bit the cycle after send_vld is accepted; each bit lasts BAUD_DIV cycles.
// Backpressure: send_vld is taken only while busy is low; requests during busy are dropped, not queued.
// Optional feature macro: UART_PARITY_EN (inserts the parity bit after d[7]).
module uart_tx_ser
    import uart_phy_pkg::*;
#(
    parameter int BAUD_DIV = 104
) (
    input  logic                 i_wb_clk,
    input  logic                 i_wb_rst_n,
    input  logic [DATA_BITS-1:0] tx_dat,
    input  logic                 send_vld,
    output logic                 tx,
    output logic                 busy
);

    localparam logic [BAUD_CNT_W-1:0] BAUD_RELOAD = BAUD_CNT_W'(BAUD_DIV - 1);

    logic [0:0]            state;
    logic [BAUD_CNT_W-1:0] baud_cnt;
    logic [BIT_CNT_W-1:0]  bits_left;
    // Everything that follows the start bit, shifted out LSB first and refilled with idle level.
    logic [FRAME_BITS-2:0] shreg;

    assign busy = (state == TX_SEND);

    // Frame sequencer: accept a byte when idle, then hold each bit for exactly BAUD_DIV cycles.
    always_ff @(posedge i_wb_clk) begin
        if (!i_wb_rst_n) begin
            state     <= TX_IDLE;
            tx        <= LINE_IDLE;
            baud_cnt  <= '0;
            bits_left <= '0;
            shreg     <= '1;
        end else begin
            case (state)
                TX_IDLE: begin
                    if (send_vld) begin
                        state     <= TX_SEND;
                        tx        <= ~LINE_IDLE;
`ifdef UART_PARITY_EN
                        shreg     <= {LINE_IDLE, even_parity(tx_dat), tx_dat};
`else
                        shreg     <= {LINE_IDLE, tx_dat};
`endif
                        bits_left <= BIT_CNT_W'(FRAME_BITS - 1);
                        baud_cnt  <= BAUD_RELOAD;
                    end
                end
                default: begin
                    if (baud_cnt != '0) begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end else if (bits_left == '0) begin
                        // Last cycle of the stop bit just ended; the next cycle may accept a new byte.
                        state <= TX_IDLE;
                        tx    <= LINE_IDLE;
                    end else begin
                        tx        <= shreg[0];
                        shreg     <= {LINE_IDLE, shreg[FRAME_BITS-2:1]};
                        bits_left <= bits_left - 1'b1;
                        baud_cnt  <= BAUD_RELOAD;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_phy.sv
// Byte-level UART PHY (8N1, optional even parity) between the CPLD pins and the uart2wb parser.
// Latency: o_received pulses 1 cycle after the mid-stop-bit sample, plus SYNC_STAGES of input sync.
// Backpressure: none on RX (strobes are fire-and-forget); i_send is honoured only while o_tx_busy is low.
// Optional feature macro: UART_PARITY_EN (parity generated on TX, checked on RX).
module uart_phy
    import uart_phy_pkg::*;
#(
    parameter int BAUD_DIV    = 104,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 i_wb_clk,
    input  logic                 i_wb_rst_n,
    input  logic                 i_rx,
    output logic                 o_tx,
    output logic [DATA_BITS-1:0] o_rx_dat,
    output logic                 o_received,
    output logic                 o_frame_err,
    input  logic [DATA_BITS-1:0] i_tx_dat,
    input  logic                 i_send,
    output logic                 o_tx_busy
);

    localparam logic [BAUD_CNT_W-1:0] BAUD_RELOAD = BAUD_CNT_W'(BAUD_DIV - 1);
    // Half a bit after the falling edge lands the sample near the middle of each bit.
    localparam logic [BAUD_CNT_W-1:0] BAUD_HALF   = BAUD_CNT_W'(BAUD_DIV / 2 - 1);

    logic [SYNC_STAGES-1:0] rx_sync;
    logic                   rx_s;
    logic                   rx_q;
    logic [2:0]             rx_state;
    logic [BAUD_CNT_W-1:0]  rx_cnt;
    logic [BIT_CNT_W-1:0]   rx_bit;
    logic [DATA_BITS-1:0]   rx_shreg;
    logic                   rx_tick;
`ifdef UART_PARITY_EN
    logic                   rx_par_bad;
`endif

    assign rx_s    = rx_sync[SYNC_STAGES-1];
    assign rx_tick = (rx_cnt == '0);

    // Synchronize the asynchronous pin and keep the previous sample for edge detection.
    always_ff @(posedge i_wb_clk) begin
        if (!i_wb_rst_n) begin
            rx_sync <= '1;
            rx_q    <= LINE_IDLE;
        end else begin
            rx_sync <= {rx_sync[SYNC_STAGES-2:0], i_rx};
            rx_q    <= rx_s;
        end
    end

    // Receiver: qualify the start bit, sample data mid-bit, check framing, emit one-cycle strobes.
    always_ff @(posedge i_wb_clk) begin
        if (!i_wb_rst_n) begin
            rx_state    <= RX_IDLE;
            rx_cnt      <= '0;
            rx_bit      <= '0;
            rx_shreg    <= '0;
            o_rx_dat    <= '0;
            o_received  <= 1'b0;
            o_frame_err <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_bad  <= 1'b0;
`endif
        end else begin
            o_received  <= 1'b0;
            o_frame_err <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_q && !rx_s) begin
                        rx_state <= RX_START;
                        rx_cnt   <= BAUD_HALF;
                    end
                end
                RX_START: begin
                    if (rx_tick) begin
                        // A line already back high mid-start-bit was a glitch: drop it silently.
                        rx_state <= rx_s ? RX_IDLE : RX_DATA;
                        rx_cnt   <= BAUD_RELOAD;
                        rx_bit   <= '0;
                    end else begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_tick) begin
                        rx_shreg <= {rx_s, rx_shreg[DATA_BITS-1:1]};
                        rx_bit   <= rx_bit + 1'b1;
                        rx_cnt   <= BAUD_RELOAD;
                        if (rx_bit == BIT_CNT_W'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                            rx_state <= RX_PARITY;
`else
                            rx_state <= RX_STOP;
`endif
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end
                end
`ifdef UART_PARITY_EN
                RX_PARITY: begin
                    if (rx_tick) begin
                        rx_par_bad <= (rx_s != even_parity(rx_shreg));
                        rx_cnt     <= BAUD_RELOAD;
                        rx_state   <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end
                end
`endif
                RX_STOP: begin
                    if (rx_tick) begin
                        if (!rx_s) begin
                            // Missing stop bit: report once, then wait out the low line.
                            o_frame_err <= 1'b1;
                            rx_state    <= RX_BREAK;
`ifdef UART_PARITY_EN
                        end else if (rx_par_bad) begin
                            o_frame_err <= 1'b1;
                            rx_state    <= RX_IDLE;
`endif
                        end else begin
                            o_rx_dat   <= rx_shreg;
                            o_received <= 1'b1;
                            rx_state   <= RX_IDLE;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end
                end
                RX_BREAK: begin
                    if (rx_s) begin
                        rx_state <= RX_IDLE;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    uart_tx_ser #(
        .BAUD_DIV (BAUD_DIV)
    ) u_tx_ser (
        .i_wb_clk   (i_wb_clk),
        .i_wb_rst_n (i_wb_rst_n),
        .tx_dat     (i_tx_dat),
        .send_vld   (i_send),
        .tx         (o_tx),
        .busy       (o_tx_busy)
    );

endmodule
